rv32i_seq_ctrl: RTL
===================

# rv32i_seq_ctrl

Multi-cycle sequencer for the RV32I core. It drives instruction fetch, latches the instruction word for the decoder, and steps the datapath through decode, execute, memory and write-back. It issues the register-file and CSR write strobes and owns the architectural PC. It sits between the instruction/data memory ports and the decoder/ALU/register-file datapath.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- run  in  1  execution enable; sampled only at instruction boundaries.
- imem_req  out  1  fetch request; held until accepted.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  fetch accept/data-valid.
- imem_rdata  in  32  fetched word.
- ir  out  32  latched instruction word; feeds the decoder.
- dec_mem_op  in  1  decoder mem_op (MEM_STORE=1).
- dec_wb_from  in  3  decoder wb_from code (WB_MEM, WB_PC, etc.).
- dec_r_we  in  1  decoder register write enable.
- dec_csr_we  in  1  decoder CSR write enable.
- dec_rd  in  5  decoder destination register.
- branch_taken  in  1  ALU branch-compare result.
- target_pc  in  32  datapath jump/branch target.
- dmem_req  out  1  data access request.
- dmem_we  out  1  store when 1, load when 0.
- dmem_ready  in  1  data access complete.
- rf_we  out  1  register-file write strobe.
- csr_we  out  1  CSR write strobe.
- pc  out  32  current instruction PC.
- halted  out  1  high in IDLE.
- fault  out  1  sticky misaligned-target fault.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- Transitions and per-state behaviour:
  - IDLE: go to FETCH when run=1.
  - FETCH: imem_req=1. When imem_ready=1, load ir from imem_rdata and go to DECODE.
  - DECODE: one cycle for decoder and register-file settle.
  - EXEC: one cycle.
    - Latch next_pc = target_pc if (dec_wb_from==WB_PC or branch_taken), else pc+4 (modulo 2^32).
    - Go to MEM if the instruction is a memory access (dec_wb_from==WB_MEM or dec_mem_op=1), else go to WB.
  - MEM: dmem_req=1 and dmem_we=dec_mem_op, held until dmem_ready=1, then go to WB.
  - WB:
    - rf_we=dec_r_we & (dec_rd!=0).
    - csr_we=dec_csr_we.
    - If next_pc[1:0]!=0: go to FAULT; pc unchanged.
    - Otherwise pc<=next_pc, then go to FETCH if run=1, else IDLE.
  - FAULT: fault=1. Stays in FAULT until rst.
- Loads write back in WB only, after dmem_ready has been seen.
- Strobes (imem_req, dmem_req, rf_we, csr_we) are Moore outputs, decoded from state only.

## Timing
- Reset values:
  - State IDLE, pc=RESET_PC, ir=32'h0000_0013 (NOP).
  - All strobes 0, halted=1, fault=0.
- rst overrides every state, including an in-flight FETCH or MEM. The request drops on the cycle after rst is sampled, and no write strobe fires.
- imem_ready/dmem_ready are sampled only while the matching req is high. Ready in the same cycle req rises counts as accepted.
- With zero-wait memory:
  - ALU/branch/jump instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- run is ignored mid-instruction: dropping run mid-instruction completes the instruction, then the FSM enters IDLE.
- pc+4 at 32'hFFFF_FFFC wraps to 0.
- rf_we and csr_we are single-cycle pulses.

## Configuration
- RV32I_SEQ_PERF_EN defined: adds outputs cycle_cnt [63:0] and instret_cnt [63:0], both reset to 0.
  - cycle_cnt increments every cycle except in IDLE and FAULT.
  - instret_cnt increments on each WB cycle that does not enter FAULT.
  - Both wrap at 2^64.
- Undefined: neither port nor counter logic exists.

## Test plan
- Zero-wait ADDI at RESET_PC=0, run=1 → imem_req in cycle 1 after reset release, rf_we pulse in cycle 4, pc=4 in cycle 5.
- LW with dmem_ready delayed 3 cycles → dmem_req held 4 cycles with dmem_we=0, rf_we pulses once after ready, total 8 cycles.
- BEQ taken, target_pc=0x100 → no rf_we, next imem_addr=0x100; not taken → imem_addr=pc+4.
- JALR with target_pc=0x102 → fault=1, state stuck in FAULT, pc unchanged, no further imem_req until rst.
- rst asserted during MEM wait → dmem_req low the next cycle, pc=RESET_PC, no rf_we; run dropped mid-instruction → halted=1 after WB.
- With RV32I_SEQ_PERF_EN, 10 zero-wait ALU instructions → instret_cnt=10, cycle_cnt=40.

Source files
------------

// File: rtl/rv32i_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rv32i_seq_ctrl
//
// Multi-cycle sequencer for the RV32I core. It fetches an instruction and
// latches it for the decoder. It then steps the datapath through DECODE, EXEC,
// optional MEM and WB. It owns the architectural PC and issues the
// register-file and CSR write strobes.
//
// Instruction flow (zero-wait memory):
//   ALU / branch / jump : FETCH -> DECODE -> EXEC -> WB          (4 cycles)
//   load / store        : FETCH -> DECODE -> EXEC -> MEM -> WB   (5 cycles)
//   Each memory wait cycle adds one cycle.
//
// Optional feature (macro RV32I_SEQ_PERF_EN):
//   When defined, the block adds the 64-bit outputs cycle_cnt and instret_cnt.
//   When undefined, neither the ports nor the counter logic exist.
//
// Parameters:
//   RESET_PC  PC loaded on reset.
//   WB_MEM    decoder wb_from code for "write back from memory" (loads).
//   WB_PC     decoder wb_from code for "write back PC+4" (JAL/JALR).
//
// Ports:
//   clk, rst         core clock; synchronous active-high reset
//   run              execution enable, sampled only at instruction boundaries
//   imem_req/addr    fetch request (held until accepted) and fetch address (=pc)
//   imem_ready/rdata fetch accept / fetched word
//   ir               latched instruction word for the decoder
//   dec_*            decoder control fields for the current instruction
//   branch_taken     ALU branch-compare result
//   target_pc        datapath jump/branch target
//   dmem_req/we      data access request; we=1 store, we=0 load
//   dmem_ready       data access complete
//   rf_we, csr_we    single-cycle write strobes, asserted in WB
//   pc               current instruction PC
//   halted           high while idle
//   fault            sticky misaligned-target fault
//   cycle_cnt        (perf only) cycles spent outside IDLE and FAULT
//   instret_cnt      (perf only) retired instructions
// -----------------------------------------------------------------------------
module rv32i_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [2:0]  WB_MEM   = 3'd1,
  parameter logic [2:0]  WB_PC    = 3'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  // instruction memory port
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  // decoder interface
  output logic [31:0] ir,
  input  logic        dec_mem_op,
  input  logic [2:0]  dec_wb_from,
  input  logic        dec_r_we,
  input  logic        dec_csr_we,
  input  logic [4:0]  dec_rd,
  // datapath
  input  logic        branch_taken,
  input  logic [31:0] target_pc,
  // data memory port
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  // write strobes and status
  output logic        rf_we,
  output logic        csr_we,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault
`ifdef RV32I_SEQ_PERF_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] next_pc;      // PC of the following instruction, captured in EXEC
  logic        is_mem;       // current instruction accesses data memory
  logic        take_target;  // jump, or branch taken
  logic        misaligned;   // captured next_pc is not word aligned

  assign is_mem      = (dec_wb_from == WB_MEM) || dec_mem_op;
  assign take_target = (dec_wb_from == WB_PC) || branch_taken;
  assign misaligned  = (next_pc[1:0] != 2'b00);

  // ---------------------------------------------------------------------------
  // State and architectural registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the clock edge regardless of the
  // order of statements or processes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= NOP;
      next_pc <= RESET_PC;
    end else begin
      state <= state_nxt;

      if (state == S_FETCH && imem_ready) begin
        ir <= imem_rdata;
      end

      // pc + 4 wraps naturally at 2^32 because the sum is kept to 32 bits.
      if (state == S_EXEC) begin
        next_pc <= take_target ? target_pc : (pc + 32'd4);
      end

      // A misaligned target leaves pc pointing at the faulting instruction.
      if (state == S_WB && !misaligned) begin
        pc <= next_pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default at the top, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = is_mem ? S_MEM : S_WB;
      S_MEM:    if (dmem_ready) state_nxt = S_WB;
      S_WB: begin
        if (misaligned) state_nxt = S_FAULT;
        else if (run)   state_nxt = S_FETCH;
        else            state_nxt = S_IDLE;
      end
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobes are decoded from the state register only, so they drop
  // on the cycle after rst is sampled. Write strobes last exactly one cycle
  // because WB is always left after one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    csr_we   = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    unique case (state)
      S_IDLE:  halted = 1'b1;
      S_FETCH: imem_req = 1'b1;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_op;
      end
      S_WB: begin
        // x0 is hard-wired to zero, so a write to it is suppressed here.
        rf_we  = dec_r_we && (dec_rd != 5'd0);
        csr_we = dec_csr_we;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;

`ifdef RV32I_SEQ_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters. Both wrap at 2^64.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= 64'd0;
      instret_cnt <= 64'd0;
    end else begin
      if (state != S_IDLE && state != S_FAULT) begin
        cycle_cnt <= cycle_cnt + 64'd1;
      end
      // An instruction retires only if its WB does not end in FAULT.
      if (state == S_WB && !misaligned) begin
        instret_cnt <= instret_cnt + 64'd1;
      end
    end
  end
`endif

endmodule
